// File: rtl/circuit_breaker.sv
// Trading circuit breaker: turns anomaly-detector alerts into order gating
// through a NORMAL / THROTTLE / HALT / COOLDOWN controller with alert logging.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   NORMAL   | all offered orders pass, trading enabled
//   THROTTLE | sustained minor alerts, 1 of every THROTTLE_DIV orders passes
//   HALT     | severe or flash-crash condition, all orders rejected
//   COOLDOWN | operator cleared the halt, throttled until the quiet timer ends
module circuit_breaker #(
  parameter int PERSIST         = 4,
  parameter int HALT_PRIO       = 6,
  parameter int COOLDOWN_CYCLES = 1024,
  parameter int THROTTLE_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alert_any,
  input  logic [2:0] alert_priority,
  input  logic [2:0] alert_type,
  input  logic [7:0] alert_bitmap,
  input  logic       order_valid,
  input  logic       halt_clear,
  output logic       order_accept,
  output logic [1:0] state_out,
  output logic       trade_enable,
  output logic       halt_active,
  output logic [2:0] last_alert_type,
  output logic [7:0] sticky_bitmap,
  output logic [7:0] halt_count
);

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_THROTTLE = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  localparam logic [3:0]  PERSIST_LAST = 4'(PERSIST - 1);
  localparam logic [2:0]  PRIO_TH      = 3'(HALT_PRIO);
  localparam logic [15:0] COOL_LOAD    = 16'(COOLDOWN_CYCLES - 1);
  localparam logic [3:0]  THR_LAST     = 4'(THROTTLE_DIV - 1);

  logic [1:0]  state, state_nxt;
  logic [3:0]  any_cnt, sev_cnt, quiet_cnt;
  logic [3:0]  thr_cnt;
  logic [15:0] timer, timer_nxt;

  logic severe, flash, quiet;
  logic any_persist, sev_persist, quiet_persist;
  logic clear_ok;
  logic throttled;
  logic entering_thr;
  logic entering_halt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign severe = alert_any && (alert_priority >= PRIO_TH);
  assign flash  = alert_bitmap[7];
  assign quiet  = !alert_any;

  // Persistence fires on the PERSIST-th consecutive qualifying cycle.
  assign any_persist   = alert_any && (any_cnt == PERSIST_LAST);
  assign sev_persist   = severe && (sev_cnt == PERSIST_LAST);
  assign quiet_persist = quiet && (quiet_cnt == PERSIST_LAST);

  assign clear_ok  = (state == ST_HALT) && halt_clear && quiet && !flash;
  assign throttled = (state == ST_THROTTLE) || (state == ST_COOLDOWN);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (flash) begin
      state_nxt = ST_HALT;
    end else begin
      case (state)
        ST_NORMAL: begin
          if (sev_persist)      state_nxt = ST_HALT;
          else if (any_persist) state_nxt = ST_THROTTLE;
        end
        ST_THROTTLE: begin
          if (sev_persist)        state_nxt = ST_HALT;
          else if (quiet_persist) state_nxt = ST_NORMAL;
        end
        ST_HALT: begin
          if (halt_clear && quiet) begin
            state_nxt = ST_COOLDOWN;
            timer_nxt = COOL_LOAD;
          end
        end
        default: begin
          if (severe)               state_nxt = ST_HALT;
          else if (alert_any)       timer_nxt = COOL_LOAD;
          else if (timer == 16'd0)  state_nxt = ST_NORMAL;
          else                      timer_nxt = timer - 16'd1;
        end
      endcase
    end
  end

  assign entering_thr  = (state_nxt != state) &&
                         ((state_nxt == ST_THROTTLE) || (state_nxt == ST_COOLDOWN));
  assign entering_halt = (state_nxt == ST_HALT) && (state != ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_NORMAL;
      timer        <= 16'd0;
      trade_enable <= 1'b1;
      halt_active  <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      trade_enable <= (state_nxt == ST_NORMAL);
      halt_active  <= (state_nxt == ST_HALT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_cnt   <= 4'd0;
      sev_cnt   <= 4'd0;
      quiet_cnt <= 4'd0;
    end else begin
      any_cnt   <= alert_any ? sat_inc(any_cnt) : 4'd0;
      sev_cnt   <= severe ? sat_inc(sev_cnt) : 4'd0;
      quiet_cnt <= quiet ? sat_inc(quiet_cnt) : 4'd0;
    end
  end

  // Zeroing on entry guarantees the first order after entering is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_cnt <= 4'd0;
    end else if (entering_thr) begin
      thr_cnt <= 4'd0;
    end else if (throttled && order_valid) begin
      thr_cnt <= (thr_cnt == THR_LAST) ? 4'd0 : thr_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_alert_type <= 3'd0;
      sticky_bitmap   <= 8'd0;
      halt_count      <= 8'd0;
    end else begin
      if (alert_any) last_alert_type <= alert_type;
      if (clear_ok) sticky_bitmap <= 8'd0;
      else          sticky_bitmap <= sticky_bitmap | alert_bitmap;
      if (entering_halt && (halt_count != 8'hFF)) halt_count <= halt_count + 8'd1;
    end
  end

  assign order_accept = order_valid &&
                        ((state == ST_NORMAL) || (throttled && (thr_cnt == 4'd0)));
  assign state_out    = state;

endmodule
